// File: rtl/uart_reg_bridge.sv
// Byte-command engine between a UART FIFO pair and a request/acknowledge register bus.
// 'W' addr data -> write, 'R' addr -> read; one response byte is pushed per command.
module uart_reg_bridge #(
    parameter int unsigned D_BITS      = 8,
    parameter int unsigned A_BITS      = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [D_BITS-1:0] r_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic [D_BITS-1:0] w_data,
    output logic              wr_uart,
    input  logic              tx_full,
    output logic              bus_req,
    output logic              bus_we,
    output logic [A_BITS-1:0] bus_addr,
    output logic [D_BITS-1:0] bus_wdata,
    input  logic [D_BITS-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy
);

    localparam int unsigned T_BITS = $clog2(ACK_TIMEOUT + 1);

    localparam logic [D_BITS-1:0] OP_WRITE = D_BITS'(8'h57);
    localparam logic [D_BITS-1:0] OP_READ  = D_BITS'(8'h52);
    localparam logic [D_BITS-1:0] RSP_OK   = D_BITS'(8'h4B);
    localparam logic [D_BITS-1:0] RSP_ERR  = D_BITS'(8'h45);
    localparam logic [D_BITS-1:0] RSP_BAD  = D_BITS'(8'h3F);
    localparam logic [T_BITS-1:0] T_LAST   = T_BITS'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t            state_q;
    logic              op_we_q;
    logic [D_BITS-1:0] resp_q;
    logic [T_BITS-1:0] timer_q;
    logic              wr_uart_q;
    logic [D_BITS-1:0] w_data_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [A_BITS-1:0] bus_addr_q;
    logic [D_BITS-1:0] bus_wdata_q;
    logic              pop;

    // The rx FIFO is first-word-fall-through, so the pop strobe and byte capture share a cycle.
    assign pop = !rx_empty &&
                 (state_q == S_IDLE || state_q == S_GET_ADDR || state_q == S_GET_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_we_q     <= 1'b0;
            resp_q      <= '0;
            timer_q     <= '0;
            wr_uart_q   <= 1'b0;
            w_data_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            wr_uart_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (r_data == OP_WRITE) begin
                            op_we_q <= 1'b1;
                            state_q <= S_GET_ADDR;
                        end else if (r_data == OP_READ) begin
                            op_we_q <= 1'b0;
                            state_q <= S_GET_ADDR;
                        end else begin
                            resp_q  <= RSP_BAD;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (pop) begin
                        bus_addr_q <= r_data[A_BITS-1:0];
                        if (op_we_q) begin
                            state_q <= S_GET_DATA;
                        end else begin
                            bus_req_q <= 1'b1;
                            bus_we_q  <= 1'b0;
                            timer_q   <= '0;
                            state_q   <= S_BUS;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (pop) begin
                        bus_wdata_q <= r_data;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= S_BUS;
                    end
                end
                S_BUS: begin
                    // An ack arriving in the final timeout cycle still wins over the abort.
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        resp_q    <= bus_we_q ? RSP_OK : bus_rdata;
                        state_q   <= S_RESP;
                    end else if (timer_q == T_LAST) begin
                        bus_req_q <= 1'b0;
                        resp_q    <= RSP_ERR;
                        state_q   <= S_RESP;
                    end else begin
                        timer_q <= timer_q + T_BITS'(1);
                    end
                end
                S_RESP: begin
                    if (!tx_full) begin
                        w_data_q  <= resp_q;
                        wr_uart_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_uart   = pop && !reset;
    assign wr_uart   = wr_uart_q;
    assign w_data    = w_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule
